// File: rtl/seg_scroll_if.sv
// seg_scroll_if: display/message bus between the anode sequencer/writer (master) and seg_scroll_driver (slave).
interface seg_scroll_if;
    logic [3:0] i_an;
    logic       i_wr_en;
    logic [3:0] i_wr_addr;
    logic [3:0] i_wr_data;
    logic       i_hold;
    logic [6:0] o_seg;
    logic       o_dp;
    logic [3:0] o_an_out;
    logic [3:0] o_pos;
    modport master (
        output i_an, i_wr_en, i_wr_addr, i_wr_data, i_hold,
        input  o_seg, o_dp, o_an_out, o_pos
    );
    modport slave (
        input  i_an, i_wr_en, i_wr_addr, i_wr_data, i_hold,
        output o_seg, o_dp, o_an_out, o_pos
    );
endinterface

// File: rtl/seg_scroll_driver.sv
// seg_scroll_driver: scrolls a 16-char hex message across a 4-digit 7-seg display.
// Define SEG_SCROLL_EN to build the scroll divider; otherwise pos is fixed at 0.
module seg_scroll_driver #(
    parameter logic [23:0] SCROLL_DIV = 24'd10_000_000
) (
    input logic         clk,
    input logic         reset,
    seg_scroll_if.slave bus
);
    logic [3:0] r_mem [16];
    logic [6:0] r_seg;
    logic       r_dp;
    logic [3:0] r_an_out;
    logic [3:0] w_pos;
    logic [3:0] w_idx;
    logic [3:0] w_char;
    logic [6:0] w_seg;
    logic       w_valid;
    logic [1:0] w_ofs;

    always_comb begin
        w_valid = (bus.i_an == 4'b0111) || (bus.i_an == 4'b1011) ||
                  (bus.i_an == 4'b1101) || (bus.i_an == 4'b1110);
        w_ofs   = (bus.i_an == 4'b1011) ? 2'd1 :
                  (bus.i_an == 4'b1101) ? 2'd2 :
                  (bus.i_an == 4'b1110) ? 2'd3 : 2'd0;
        w_idx   = w_pos + {2'b00, w_ofs};
        w_char  = r_mem[w_idx];
    end

    always_comb begin
        w_seg = 7'b1111111;
        case (w_char)
            4'h0: w_seg = 7'b0000001;
            4'h1: w_seg = 7'b1001111;
            4'h2: w_seg = 7'b0010010;
            4'h3: w_seg = 7'b0000110;
            4'h4: w_seg = 7'b1001100;
            4'h5: w_seg = 7'b0100100;
            4'h6: w_seg = 7'b0100000;
            4'h7: w_seg = 7'b0001111;
            4'h8: w_seg = 7'b0000000;
            4'h9: w_seg = 7'b0000100;
            4'hA: w_seg = 7'b0001000;
            4'hB: w_seg = 7'b1100000;
            4'hC: w_seg = 7'b0110001;
            4'hD: w_seg = 7'b1000010;
            4'hE: w_seg = 7'b0110000;
            4'hF: w_seg = 7'b0111000;
            default: w_seg = 7'b1111111;
        endcase
    end

    // Reads above see the pre-write contents, so a write shows up one cycle later.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) r_mem[i] <= 4'(i);
        end else if (bus.i_wr_en) begin
            r_mem[bus.i_wr_addr] <= bus.i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_seg    <= 7'b1111111;
            r_dp     <= 1'b1;
            r_an_out <= 4'b1111;
        end else begin
            r_seg    <= w_valid ? w_seg : 7'b1111111;
            r_dp     <= w_valid ? (w_idx != 4'd0) : 1'b1;
            r_an_out <= w_valid ? bus.i_an : 4'b1111;
        end
    end

`ifdef SEG_SCROLL_EN
    logic [23:0] r_div;
    logic [3:0]  r_pos;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_div <= 24'd0;
            r_pos <= 4'd0;
        end else if (!bus.i_hold) begin
            if (r_div == SCROLL_DIV - 24'd1) begin
                r_div <= 24'd0;
                r_pos <= r_pos + 4'd1;
            end else begin
                r_div <= r_div + 24'd1;
            end
        end
    end

    assign w_pos = r_pos;
`else
    logic w_unused;
    assign w_unused = ^{bus.i_hold, SCROLL_DIV};
    assign w_pos    = 4'd0;
`endif

    assign bus.o_seg    = r_seg;
    assign bus.o_dp     = r_dp;
    assign bus.o_an_out = r_an_out;
    assign bus.o_pos    = w_pos;
endmodule

// File: tb/tb_seg_scroll_driver.sv
// tb_seg_scroll_driver: directed vector table plus hand sequences for scroll, hold, write and reset.
module tb_seg_scroll_driver;
    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;

    seg_scroll_if bus ();

    seg_scroll_driver #(.SCROLL_DIV(24'd4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an_out;
    } vec_t;

    vec_t vecs [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [6:0] seg, input logic dp, input logic [3:0] an_out);
        chk({name, "_seg"}, 32'(bus.o_seg), 32'(seg));
        chk({name, "_dp"}, 32'(bus.o_dp), 32'(dp));
        chk({name, "_an"}, 32'(bus.o_an_out), 32'(an_out));
    endtask

    initial begin
        vecs[0] = '{4'b0111, 7'b0000001, 1'b0, 4'b0111};
        vecs[1] = '{4'b1011, 7'b1001111, 1'b1, 4'b1011};
        vecs[2] = '{4'b1101, 7'b0010010, 1'b1, 4'b1101};
        vecs[3] = '{4'b1110, 7'b0000110, 1'b1, 4'b1110};
        vecs[4] = '{4'b1111, 7'b1111111, 1'b1, 4'b1111};
        vecs[5] = '{4'b0011, 7'b1111111, 1'b1, 4'b1111};
        vecs[6] = '{4'b0000, 7'b1111111, 1'b1, 4'b1111};
        vecs[7] = '{4'b1100, 7'b1111111, 1'b1, 4'b1111};

        reset = 1'b0;
        bus.i_an = 4'b0111;
        bus.i_hold = 1'b1;
        bus.i_wr_en = 1'b1;
        bus.i_wr_addr = 4'd0;
        bus.i_wr_data = 4'hF;
        step();
        step();
        chk_out("rst", 7'b1111111, 1'b1, 4'b1111);
        chk("rst_pos", 32'(bus.o_pos), 32'd0);

        reset = 1'b1;
        bus.i_wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.i_an = vecs[i].an;
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].seg, vecs[i].dp, vecs[i].an_out);
            chk($sformatf("vec%0d_pos", i), 32'(bus.o_pos), 32'd0);
        end

`ifdef SEG_SCROLL_EN
        repeat (20) step();
        chk("hold_init_pos", 32'(bus.o_pos), 32'd0);
        bus.i_hold = 1'b0;
        bus.i_an = 4'b0111;
        repeat (3) step();
        chk("div_pre_pos", 32'(bus.o_pos), 32'd0);
        step();
        chk("div_term_pos", 32'(bus.o_pos), 32'd1);
        chk_out("pos0_view", 7'b0000001, 1'b0, 4'b0111);
        step();
        chk_out("pos1_view", 7'b1001111, 1'b1, 4'b0111);
        bus.i_hold = 1'b1;
        repeat (20) step();
        chk("hold_mid_pos", 32'(bus.o_pos), 32'd1);
        bus.i_hold = 1'b0;
        repeat (51) step();
        chk("pos14", 32'(bus.o_pos), 32'd14);
        bus.i_an = 4'b1101;
        step();
        chk_out("wrap_d2", 7'b0000001, 1'b0, 4'b1101);
        bus.i_an = 4'b1110;
        step();
        chk_out("wrap_d3", 7'b1001111, 1'b1, 4'b1110);
        repeat (5) step();
        chk("pos15", 32'(bus.o_pos), 32'd15);
        step();
        chk("pos_wrap0", 32'(bus.o_pos), 32'd0);
        bus.i_hold = 1'b1;
`else
        bus.i_hold = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            chk("nodiv_pos", 32'(bus.o_pos), 32'd0);
        end
        bus.i_hold = 1'b1;
`endif

        bus.i_an = 4'b0111;
        bus.i_wr_en = 1'b1;
        bus.i_wr_addr = 4'd0;
        bus.i_wr_data = 4'hF;
        step();
        chk_out("wr_same", 7'b0000001, 1'b0, 4'b0111);
        bus.i_wr_addr = 4'd2;
        bus.i_wr_data = 4'hC;
        step();
        chk_out("wr_next", 7'b0111000, 1'b0, 4'b0111);
        bus.i_wr_en = 1'b0;
        bus.i_an = 4'b1101;
        step();
        chk_out("wr_c", 7'b0110001, 1'b1, 4'b1101);

        bus.i_hold = 1'b0;
        repeat (6) step();
`ifdef SEG_SCROLL_EN
        chk("mid_scroll_pos", 32'(bus.o_pos), 32'd1);
`endif
        reset = 1'b0;
        bus.i_wr_en = 1'b1;
        bus.i_wr_addr = 4'd1;
        bus.i_wr_data = 4'hE;
        step();
        chk_out("rst2", 7'b1111111, 1'b1, 4'b1111);
        chk("rst2_pos", 32'(bus.o_pos), 32'd0);

        reset = 1'b1;
        bus.i_wr_en = 1'b0;
        bus.i_hold = 1'b1;
        bus.i_an = 4'b0111;
        step();
        chk_out("rest_m0", 7'b0000001, 1'b0, 4'b0111);
        bus.i_an = 4'b1101;
        step();
        chk_out("rest_m2", 7'b0010010, 1'b1, 4'b1101);
        bus.i_an = 4'b1011;
        step();
        chk_out("rest_m1", 7'b1001111, 1'b1, 4'b1011);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
